// File: rtl/perf_counter_readout_sequencer_if.sv
// Word stream from the readout sequencer toward the host/debug path.
// Carries one captured counter word per valid/ready transfer.
interface perf_counter_readout_sequencer_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic [5:0]  addr;
  logic        last;

  modport master (output valid, data, addr, last, input ready);
  modport slave  (input valid, data, addr, last, output ready);
endinterface

// File: rtl/perf_counter_readout_sequencer.sv
// Walks a contiguous range of performance-counter readout addresses, optionally
// freezing counting, and streams each returned 32-bit word out over valid/ready.
module perf_counter_readout_sequencer #(
  parameter int unsigned START_ADDR  = 0,
  parameter int unsigned END_ADDR    = 19,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter bit          FREEZE      = 1'b1,
  parameter logic [1:0]  SELECT      = 2'b00
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        count_en_i,
  input  logic [31:0] perf_data_i,
  output logic [31:0] comm_o,
  output logic [1:0]  select_o,
  perf_counter_readout_sequencer_if.master word,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [5:0] START_A   = START_ADDR[5:0];
  localparam logic [5:0] END_A     = END_ADDR[5:0];
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t      state;
  logic [5:0]  addr_q;
  logic [3:0]  wait_cnt;
  logic        valid_q;
  logic        last_q;
  logic [31:0] data_q;
  logic [5:0]  word_addr_q;
  logic        busy_q;
  logic        done_q;

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see the pre-edge values; the captured word registers are reset too because
  // they are directly visible on the output stream.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state       <= S_IDLE;
      addr_q      <= START_A;
      wait_cnt    <= 4'd0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= 32'd0;
      word_addr_q <= 6'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state != S_IDLE && abort_i) begin
        // A transfer on this same edge still completes at the consumer side.
        state   <= S_IDLE;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i && !abort_i) begin
              state  <= S_ISSUE;
              addr_q <= START_A;
              busy_q <= 1'b1;
            end
          end
          S_ISSUE: begin
            wait_cnt <= WAIT_LOAD;
            state    <= S_WAIT;
          end
          S_WAIT: begin
            if (wait_cnt == 4'd0) begin
              data_q      <= perf_data_i;
              word_addr_q <= addr_q;
              valid_q     <= 1'b1;
              last_q      <= (addr_q == END_A);
              state       <= S_EMIT;
            end else begin
              wait_cnt <= wait_cnt - 4'd1;
            end
          end
          S_EMIT: begin
            if (word.ready) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              if (last_q) begin
                state  <= S_DONE;
                done_q <= 1'b1;
              end else begin
                addr_q <= addr_q + 6'd1;
                state  <= S_ISSUE;
              end
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign comm_o     = {7'd0, count_en_i & ~(FREEZE & busy_q), 18'd0, addr_q};
  assign select_o   = SELECT;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign word.valid = valid_q;
  assign word.data  = data_q;
  assign word.addr  = word_addr_q;
  assign word.last  = last_q;

endmodule

// File: tb/tb_perf_counter_readout_sequencer.sv
// Scoreboard bench for the readout sequencer with a 2-cycle registered
// controller model returning 0xA000_0000 | address.
module tb_perf_counter_readout_sequencer;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        abort_i;
  logic        count_en_i;
  logic [31:0] perf_data_i;
  logic [31:0] comm_o;
  logic [1:0]  select_o;
  logic        busy_o;
  logic        done_o;

  perf_counter_readout_sequencer_if word_if();

  perf_counter_readout_sequencer dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .count_en_i  (count_en_i),
    .perf_data_i (perf_data_i),
    .comm_o      (comm_o),
    .select_o    (select_o),
    .word        (word_if),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clock_i = ~clock_i;

  // Controller model: registered read path, two edges of latency.
  logic [5:0] d1, d2;
  always @(posedge clock_i) begin
    d1 <= comm_o[5:0];
    d2 <= d1;
  end
  assign perf_data_i = 32'hA000_0000 | {26'd0, d2};

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
    logic        last;
  } word_t;

  word_t sb[$];
  int    n_checks   = 0;
  int    n_errors   = 0;
  int    done_count = 0;
  int    cyc_no     = 0;
  int    t_start    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clock_i) cyc_no <= cyc_no + 1;

  // Output monitor: pops the scoreboard on each transfer and checks hold stability.
  logic        hold_prev = 1'b0;
  logic [31:0] held_data;
  logic [5:0]  held_addr;
  always @(negedge clock_i) begin
    word_t e;
    if (hold_prev) begin
      check("hold_valid", {31'd0, word_if.valid}, 32'd1);
      check("hold_data", word_if.data, held_data);
      check("hold_addr", {26'd0, word_if.addr}, {26'd0, held_addr});
    end
    hold_prev <= word_if.valid && !word_if.ready && !reset_i && !abort_i;
    held_data <= word_if.data;
    held_addr <= word_if.addr;
    if (done_o) done_count <= done_count + 1;
    if (word_if.valid && word_if.ready) begin
      check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("word_addr", {26'd0, word_if.addr}, {26'd0, e.addr});
        check("word_data", word_if.data, e.data);
        check("word_last", {31'd0, word_if.last}, {31'd0, e.last});
      end
    end
  end

  task automatic push_walk(input int first, input int last_a);
    word_t e;
    for (int a = first; a <= last_a; a++) begin
      e.addr = 6'(a);
      e.data = 32'hA000_0000 | 32'(a);
      e.last = (a == 19);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(posedge clock_i); #1 start_i = 1'b1;
    @(posedge clock_i); #1 start_i = 1'b0;
    t_start = cyc_no;
  endtask

  // The start cycle counts as cycle 1; poke > 0 re-pulses start_i mid-walk.
  task automatic wait_done(input int budget, input int poke, input int exp_lat);
    int lat;
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock_i);
      lat = cyc_no - t_start + 1;
      if (poke > 0) start_i = (lat == poke);
      if (done_o) seen = 1'b1;
      else check("freeze_busy", {30'd0, busy_o, comm_o[24]}, 32'd2);
    end
    start_i = 1'b0;
    check("done_seen", {31'd0, seen}, 32'd1);
    if (seen) check("done_latency", lat, exp_lat);
    @(negedge clock_i);
    check("done_width", {31'd0, done_o}, 32'd0);
    check("idle_busy", {31'd0, busy_o}, 32'd0);
    check("idle_enable", {31'd0, comm_o[24]}, {31'd0, count_en_i});
    check("sb_drained", sb.size(), 32'd0);
  endtask

  task automatic wait_addr(input logic [5:0] a, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clock_i);
      found = busy_o && (comm_o[5:0] == a);
    end
    check("addr_reached", {31'd0, found}, 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clock_i);
      found = word_if.valid;
    end
    check("valid_reached", {31'd0, found}, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_comm"}, comm_o, 32'h0100_0000);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_valid"}, {31'd0, word_if.valid}, 32'd0);
    check({tag, "_last"}, {31'd0, word_if.last}, 32'd0);
    check({tag, "_done"}, {31'd0, done_o}, 32'd0);
    check({tag, "_data"}, word_if.data, 32'd0);
    check({tag, "_waddr"}, {26'd0, word_if.addr}, 32'd0);
  endtask

  initial begin
    int dc;
    reset_i       = 1'b1;
    start_i       = 1'b0;
    abort_i       = 1'b0;
    count_en_i    = 1'b1;
    word_if.ready = 1'b1;
    repeat (3) @(posedge clock_i);
    #1 reset_i = 1'b0;
    @(negedge clock_i);
    check_reset_state("reset");
    check("select", {30'd0, select_o}, 32'd0);

    // Default walk, ready tied high.
    push_walk(0, 19);
    pulse_start();
    wait_done(200, 0, 81);
    check("done_count_1", done_count, 32'd1);

    // start_i while busy is ignored.
    push_walk(0, 19);
    pulse_start();
    wait_done(200, 30, 81);
    check("done_count_2", done_count, 32'd2);

    // start_i together with abort_i in IDLE starts nothing.
    @(posedge clock_i); #1 start_i = 1'b1; abort_i = 1'b1;
    @(posedge clock_i); #1 start_i = 1'b0; abort_i = 1'b0;
    repeat (5) begin
      @(negedge clock_i);
      check("start_abort_busy", {31'd0, busy_o}, 32'd0);
      check("start_abort_valid", {31'd0, word_if.valid}, 32'd0);
    end

    // Backpressure on address 3 for five cycles.
    push_walk(0, 19);
    pulse_start();
    wait_addr(6'd3, 40);
    @(posedge clock_i); #1 word_if.ready = 1'b0;
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      check("stall_addr", {26'd0, word_if.addr}, 32'd3);
      check("stall_data", word_if.data, 32'hA000_0003);
      check("stall_no_issue", {26'd0, comm_o[5:0]}, 32'd3);
      if (i < 4) @(negedge clock_i);
    end
    @(posedge clock_i); #1 word_if.ready = 1'b1;
    wait_done(200, 0, 86);

    // Abort during WAIT of address 7.
    dc = done_count;
    push_walk(0, 6);
    pulse_start();
    wait_addr(6'd7, 60);
    @(posedge clock_i); #1 abort_i = 1'b1;
    @(posedge clock_i); #1 abort_i = 1'b0;
    @(negedge clock_i);
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_enable", {31'd0, comm_o[24]}, 32'd1);
    repeat (8) begin
      @(negedge clock_i);
      check("abort_valid", {31'd0, word_if.valid}, 32'd0);
    end
    check("abort_no_done", done_count, dc);
    check("abort_sb", sb.size(), 32'd0);
    count_en_i = 1'b0;
    #1 check("enable_follows", {31'd0, comm_o[24]}, 32'd0);
    count_en_i = 1'b1;

    // Reset while a word is held in EMIT, then a clean full walk.
    word_if.ready = 1'b0;
    pulse_start();
    wait_valid(10);
    @(posedge clock_i); #1 reset_i = 1'b1;
    @(posedge clock_i); #1 reset_i = 1'b0;
    @(negedge clock_i);
    check_reset_state("emit_reset");
    word_if.ready = 1'b1;
    push_walk(0, 19);
    pulse_start();
    wait_done(200, 0, 81);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
